// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared constants and state encoding for the memory access unit
// Purpose: ON/OFF levels, the NOP instruction loaded into IR on reset or aborted
//          fetch, and the MAU_IDLE/MAU_ACCESS/MAU_DONE state encodings.
// Ports:   none (package).
package mem_access_unit_pkg;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  // addi x0, x0, 0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    MAU_IDLE   = 2'd0,
    MAU_ACCESS = 2'd1,
    MAU_DONE   = 2'd2
  } mau_state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - control/datapath and memory-side signal bundle of the memory access unit
// Purpose: groups the control strobes, datapath operands, memory bus and the
//          IR/MDR/status outputs of mem_access_unit.
// Ports:   slave modport  - seen by mem_access_unit (strobes/operands/memory
//                           response in; memory request, IR, MDR, status out).
//          master modport - seen by the control FSM, datapath and memory model.
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  // control FSM strobes and datapath operands
  logic              iLeMem;
  logic              iEscreveMem;
  logic              iIouD;
  logic              iEscreveIR;
  logic [ADDR_W-1:0] iPC;
  logic [ADDR_W-1:0] iALUOut;
  logic [DATA_W-1:0] iWData;

  // memory bus
  logic [ADDR_W-1:0] oMemAddr;
  logic [DATA_W-1:0] oMemWData;
  logic              oMemRead;
  logic              oMemWrite;
  logic [DATA_W-1:0] iMemRData;
  logic              iMemReady;

  // results and status
  logic [DATA_W-1:0] oIR;
  logic [6:0]        oOpCode;
  logic [DATA_W-1:0] oMDR;
  logic              oBusy;
  logic              oErr;

  modport slave (
    input  iLeMem, iEscreveMem, iIouD, iEscreveIR, iPC, iALUOut, iWData,
    input  iMemRData, iMemReady,
    output oMemAddr, oMemWData, oMemRead, oMemWrite,
    output oIR, oOpCode, oMDR, oBusy, oErr
  );

  modport master (
    output iLeMem, iEscreveMem, iIouD, iEscreveIR, iPC, iALUOut, iWData,
    output iMemRData, iMemReady,
    input  oMemAddr, oMemWData, oMemRead, oMemWrite,
    input  oIR, oOpCode, oMDR, oBusy, oErr
  );

endinterface

// File: rtl/mem_access_unit_timeout_counter.sv
// rtl/mem_access_unit_timeout_counter.sv - ACCESS-cycle counter with terminal-count flag
// Purpose: counts cycles while enabled; tc_o is high during the TIMEOUT_CYC-th
//          enabled cycle so the owner can abort on that edge.
// Ports:   clk_i, rst_i (async, active-high), clr_i (synchronous clear, wins),
//          en_i (count this cycle), tc_o (terminal count reached this cycle).
module mau_timeout_counter #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != CW'(TIMEOUT_CYC))) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of already-completed enabled cycles
  assign tc_o = en_i & ~clr_i & (count_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-side stage: strobe-to-handshake conversion, IR/MDR, stall
// Purpose: turns the control FSM's level strobes into a ready-handshaked memory
//          access, captures read data into IR or MDR, stalls control via oBusy
//          and flags timeouts / conflicting requests on the sticky oErr.
// Ports:   iCLK  - clock, rising edge
//          iRST  - asynchronous reset, active-high
//          bus   - mem_access_unit_if.slave: iLeMem/iEscreveMem/iIouD/iEscreveIR,
//                  iPC/iALUOut/iWData in; oMemAddr/oMemWData/oMemRead/oMemWrite
//                  out, iMemRData/iMemReady in; oIR/oOpCode/oMDR/oBusy/oErr out.
// Config:  MISALIGN_CHECK_EN - when defined, misaligned data accesses are not
//          issued and set oErr; otherwise address bits [1:0] are forced to 0.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 15
) (
  input logic                iCLK,
  input logic                iRST,
  mem_access_unit_if.slave   bus
);

  mau_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_q;
  logic              wr_q;
  logic              dest_ir_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] mdr_q;
  logic              err_q;

  logic              req;
  logic              both_req;
  logic              misalign;
  logic              timeout;
  logic [ADDR_W-1:0] addr_sel;
  logic [ADDR_W-1:0] addr_issue;

  assign req      = bus.iLeMem | bus.iEscreveMem;
  assign both_req = bus.iLeMem & bus.iEscreveMem;
  assign addr_sel = bus.iIouD ? bus.iALUOut : bus.iPC;

`ifdef MISALIGN_CHECK_EN
  assign addr_issue = addr_sel;
  assign misalign   = bus.iIouD & (addr_sel[1:0] != 2'b00);
`else
  assign addr_issue = addr_sel & ~(ADDR_W'(3));
  assign misalign   = 1'b0;
`endif

  mau_timeout_counter #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk_i (iCLK),
    .rst_i (iRST),
    .clr_i (state_q != MAU_ACCESS),
    .en_i  (state_q == MAU_ACCESS),
    .tc_o  (timeout)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= MAU_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= OFF;
      wr_q      <= OFF;
      dest_ir_q <= OFF;
      ir_q      <= DATA_W'(INSTR_NOP);
      mdr_q     <= '0;
      err_q     <= OFF;
    end else begin
      case (state_q)
        MAU_IDLE: begin
          if (req) begin
            if (both_req) begin
              err_q <= ON;
            end
            if (misalign) begin
              err_q   <= ON;
              state_q <= MAU_DONE;
            end else begin
              addr_q    <= addr_issue;
              wdata_q   <= bus.iWData;
              // write takes precedence when both strobes are raised
              wr_q      <= bus.iEscreveMem;
              rd_q      <= ~bus.iEscreveMem;
              // instruction fetches only: a data read never lands in IR
              dest_ir_q <= bus.iEscreveIR & ~bus.iIouD;
              state_q   <= MAU_ACCESS;
            end
          end
        end
        MAU_ACCESS: begin
          if (bus.iMemReady) begin
            if (rd_q) begin
              if (dest_ir_q) begin
                ir_q <= bus.iMemRData;
              end else begin
                mdr_q <= bus.iMemRData;
              end
            end
            rd_q    <= OFF;
            wr_q    <= OFF;
            state_q <= MAU_DONE;
          end else if (timeout) begin
            // an aborted fetch leaves a harmless NOP for decode
            if (rd_q && dest_ir_q) begin
              ir_q <= DATA_W'(INSTR_NOP);
            end
            rd_q    <= OFF;
            wr_q    <= OFF;
            err_q   <= ON;
            state_q <= MAU_DONE;
          end
        end
        MAU_DONE: begin
          state_q <= MAU_IDLE;
        end
        default: begin
          state_q <= MAU_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.oBusy = 1'b0;
    case (state_q)
      MAU_IDLE:   bus.oBusy = req;
      MAU_ACCESS: bus.oBusy = 1'b1;
      default:    bus.oBusy = 1'b0;
    endcase
  end

  assign bus.oMemAddr  = addr_q;
  assign bus.oMemWData = wdata_q;
  assign bus.oMemRead  = rd_q;
  assign bus.oMemWrite = wr_q;
  assign bus.oIR       = ir_q;
  assign bus.oOpCode   = ir_q[6:0];
  assign bus.oMDR      = mdr_q;
  assign bus.oErr      = err_q;

endmodule
